mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_pkg.sv | 17 +
 rtl/mem_port_arbiter_arb_pick.sv | 32 +++
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the line-port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned LINE_BITS = 512;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_t;

  typedef enum logic {
    REQ_IF,
    REQ_DM
  } req_id_t;

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Winner selection between the IF and DM pending slots.
// ARB_RR_EN selects round-robin on contention; otherwise DM has fixed priority.
module arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic    if_vld_i,
  input  logic    dm_vld_i,
  input  req_id_t last_i,
  output req_id_t pick_o,
  output logic    found_o
);

`ifndef ARB_RR_EN
  logic unused_last;
  assign unused_last = last_i;
`endif

  always_comb begin
    found_o = if_vld_i | dm_vld_i;
    pick_o  = REQ_IF;
    if (if_vld_i && dm_vld_i) begin
`ifdef ARB_RR_EN
      pick_o = (last_i == REQ_DM) ? REQ_IF : REQ_DM;
`else
      pick_o = REQ_DM;
`endif
    end else if (dm_vld_i) begin
      pick_o = REQ_DM;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one line-wide cache/memory port between fetch (IF) and data (DM) requesters.
// Define ARB_RR_EN for round-robin on contention; default is DM-over-IF fixed priority.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned LINE_BYTES     = 64,
  parameter bit          PROTO_CHECK_EN = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           if_enable,
  input  logic [63:0]    if_addr,
  output logic [511:0]   if_data,
  output logic           if_done,
  input  logic           dm_enable,
  input  logic           dm_write,
  input  logic [63:0]    dm_addr,
  input  logic [511:0]   dm_wdata,
  output logic [511:0]   dm_rdata,
  output logic           dm_done,
  output logic           mem_enable,
  output logic           mem_write,
  output logic [63:0]    mem_addr,
  output logic [511:0]   mem_wdata,
  input  logic [511:0]   mem_rdata,
  input  logic           mem_done
);

  localparam int unsigned OFS_BITS   = $clog2(LINE_BYTES);
  localparam logic [63:0] ALIGN_MASK = ~((64'd1 << OFS_BITS) - 64'd1);

  arb_state_t             state_q, state_d;
  logic                   if_vld_q, dm_vld_q, dm_wr_q;
  logic [63:0]            if_addr_q, dm_addr_q;
  logic [LINE_BITS-1:0]   dm_wdata_q;
  req_id_t                cur_q, last_q;
  logic                   mem_enable_q, mem_write_q;
  logic [63:0]            mem_addr_q;
  logic [LINE_BITS-1:0]   mem_wdata_q, if_data_q, dm_rdata_q;
  logic                   if_done_q, dm_done_q;

  req_id_t pick;
  logic    found, load, finish, if_take, dm_take, if_clr, dm_clr;

  arb_pick u_pick (
    .if_vld_i (if_vld_q),
    .dm_vld_i (dm_vld_q),
    .last_i   (last_q),
    .pick_o   (pick),
    .found_o  (found)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      IDLE:  if (found) begin
               load    = 1'b1;
               state_d = ISSUE;
             end
      ISSUE: state_d = WAIT;
      WAIT:  if (mem_done) begin
               finish  = 1'b1;
               state_d = IDLE;
             end
      default: state_d = IDLE;
    endcase
  end

  // A slot stays valid through its whole flight, so repeat pulses are dropped until it completes.
  assign if_take = if_enable & ~if_vld_q;
  assign dm_take = dm_enable & ~dm_vld_q;
  assign if_clr  = finish & (cur_q == REQ_IF);
  assign dm_clr  = finish & (cur_q == REQ_DM);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      if_vld_q     <= 1'b0;
      dm_vld_q     <= 1'b0;
      dm_wr_q      <= 1'b0;
      if_addr_q    <= '0;
      dm_addr_q    <= '0;
      dm_wdata_q   <= '0;
      cur_q        <= REQ_IF;
      last_q       <= REQ_DM;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_data_q    <= '0;
      dm_rdata_q   <= '0;
      if_done_q    <= 1'b0;
      dm_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_enable_q <= load;
      if_done_q    <= if_clr;
      dm_done_q    <= dm_clr;

      if (if_clr) if_vld_q <= 1'b0;
      if (if_take) begin
        if_vld_q  <= 1'b1;
        if_addr_q <= if_addr & ALIGN_MASK;
      end
      if (dm_clr) dm_vld_q <= 1'b0;
      if (dm_take) begin
        dm_vld_q   <= 1'b1;
        dm_wr_q    <= dm_write;
        dm_addr_q  <= dm_addr & ALIGN_MASK;
        dm_wdata_q <= dm_wdata;
      end

      if (load) begin
        cur_q       <= pick;
        mem_write_q <= (pick == REQ_DM) && dm_wr_q;
        mem_addr_q  <= (pick == REQ_DM) ? dm_addr_q : if_addr_q;
        mem_wdata_q <= ((pick == REQ_DM) && dm_wr_q) ? dm_wdata_q : '0;
        if (if_vld_q && dm_vld_q) last_q <= pick;
      end

      if (if_clr) if_data_q <= mem_rdata;
      if (dm_clr && !mem_write_q) dm_rdata_q <= mem_rdata;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (PROTO_CHECK_EN && !reset) begin
      if (if_enable && if_vld_q) $error("mem_port_arbiter: if_enable while IF slot busy");
      if (dm_enable && dm_vld_q) $error("mem_port_arbiter: dm_enable while DM slot busy");
      if (mem_done && state_q != WAIT) $error("mem_port_arbiter: mem_done outside WAIT");
    end
  end
`endif

  assign if_data    = if_data_q;
  assign if_done    = if_done_q;
  assign dm_rdata   = dm_rdata_q;
  assign dm_done    = dm_done_q;
  assign mem_enable = mem_enable_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed checks of mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         if_enable = 1'b0;
  logic [63:0]  if_addr = '0;
  logic [511:0] if_data;
  logic         if_done;
  logic         dm_enable = 1'b0;
  logic         dm_write = 1'b0;
  logic [63:0]  dm_addr = '0;
  logic [511:0] dm_wdata = '0;
  logic [511:0] dm_rdata;
  logic         dm_done;
  logic         mem_enable, mem_write;
  logic [63:0]  mem_addr;
  logic [511:0] mem_wdata;
  logic [511:0] mem_rdata = '0;
  logic         mem_done = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  mem_port_arbiter #(.LINE_BYTES(64), .PROTO_CHECK_EN(1'b0)) dut (
    .clk(clk), .reset(reset),
    .if_enable(if_enable), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
    .dm_enable(dm_enable), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done),
    .mem_enable(mem_enable), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Port responder state
  int           done_at = -100;
  int           lat_fix = 0;
  bit           stray_en = 1'b0;
  bit           rd_fixed = 1'b0;
  logic [511:0] rd_pat = '0;

  task automatic step();
    @(posedge clk);
    #1;
    if_enable = 1'b0;
    dm_enable = 1'b0;
    reset     = 1'b0;
    mem_done  = 1'b0;
    mem_rdata = rd_fixed ? rd_pat : rand512();
    if (done_at == cyc) mem_done = 1'b1;
    else if (stray_en && done_at < cyc && $urandom_range(0, 15) == 0) mem_done = 1'b1;
    if (mem_enable === 1'b1)
      done_at = cyc + ((lat_fix != 0) ? lat_fix : int'($urandom_range(1, 5)));
  endtask

  // Transaction-level reference model
  bit           m_ready = 1'b0;
  bit           m_if_v, m_dm_v, m_dm_w, m_busy, m_who, m_last_dm, m_loaded;
  logic [63:0]  m_if_a, m_dm_a;
  logic [511:0] m_dm_wd;
  int           m_issue, m_if_done_at, m_dm_done_at;
  logic         exp_mem_w;
  logic [63:0]  exp_mem_a;
  logic [511:0] exp_mem_wd, exp_if_data, exp_dm_rdata;

  always @(negedge clk) begin
    bit cap_if, cap_dm, pick_dm;
    if (m_ready) begin
      chk("mem_enable", mem_enable, m_busy && (m_issue == cyc));
      chk("mem_write", mem_write, exp_mem_w);
      chk("mem_addr", mem_addr, exp_mem_a);
      if (exp_mem_w || !m_loaded) chk("mem_wdata", mem_wdata, exp_mem_wd);
      chk("if_done", if_done, m_if_done_at == cyc);
      chk("if_data", if_data, exp_if_data);
      chk("dm_done", dm_done, m_dm_done_at == cyc);
      chk("dm_rdata", dm_rdata, exp_dm_rdata);
    end
    if (reset) begin
      m_ready = 1'b1; m_if_v = 1'b0; m_dm_v = 1'b0; m_dm_w = 1'b0; m_busy = 1'b0;
      m_last_dm = 1'b1; m_loaded = 1'b0; m_if_done_at = -1; m_dm_done_at = -1;
      exp_mem_w = 1'b0; exp_mem_a = '0; exp_mem_wd = '0; exp_if_data = '0; exp_dm_rdata = '0;
    end else if (m_ready) begin
      cap_if = if_enable && !m_if_v;
      cap_dm = dm_enable && !m_dm_v;
      if (!m_busy && (m_if_v || m_dm_v)) begin
        if (m_if_v && m_dm_v) begin
`ifdef ARB_RR_EN
          pick_dm = !m_last_dm;
`else
          pick_dm = 1'b1;
`endif
          m_last_dm = pick_dm;
        end else begin
          pick_dm = m_dm_v;
        end
        m_busy = 1'b1; m_who = pick_dm; m_issue = cyc + 1; m_loaded = 1'b1;
        exp_mem_w  = pick_dm && m_dm_w;
        exp_mem_a  = pick_dm ? m_dm_a : m_if_a;
        exp_mem_wd = exp_mem_w ? m_dm_wd : '0;
      end else if (m_busy && cyc > m_issue && mem_done) begin
        if (!m_who) begin
          exp_if_data = mem_rdata; m_if_done_at = cyc + 1; m_if_v = 1'b0;
        end else begin
          if (!m_dm_w) exp_dm_rdata = mem_rdata;
          m_dm_done_at = cyc + 1; m_dm_v = 1'b0;
        end
        m_busy = 1'b0;
      end
      if (cap_if) begin m_if_v = 1'b1; m_if_a = if_addr & ~64'h3F; end
      if (cap_dm) begin
        m_dm_v = 1'b1; m_dm_w = dm_write; m_dm_a = dm_addr & ~64'h3F; m_dm_wd = dm_wdata;
      end
    end
  end

  initial begin
    int n, t0, e1, e2, cnt_if, cnt_dm, cnt_en, ng, dmd;
    logic [63:0]  a1, a2;
    logic [63:0]  ga [3];
    logic [511:0] pa5, p5a, pdead;
    pa5   = {64{8'hA5}};
    p5a   = {64{8'h5A}};
    pdead = {32{16'hDEAD}};

    // Reset values
    reset = 1'b1;
    repeat (3) begin step(); reset = 1'b1; end
    step();
    chk("rst_if_done", if_done, 0);
    chk("rst_dm_done", dm_done, 0);
    chk("rst_mem_enable", mem_enable, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_if_data", if_data, 0);
    chk("rst_dm_rdata", dm_rdata, 0);

    // Single fetch
    lat_fix = 4; rd_fixed = 1'b1; rd_pat = pa5;
    if_enable = 1'b1; if_addr = 64'h1007; t0 = cyc;
    step(); step();
    chk("fetch_issue", mem_enable, 1);
    chk("fetch_addr", mem_addr, 64'h1000);
    chk("fetch_write", mem_write, 0);
    n = 0;
    while (if_done !== 1'b1 && n < 20) begin step(); n++; end
    chk("fetch_done_lat", cyc - t0, 7);
    chk("fetch_data", if_data, pa5);
    repeat (3) step();

    // Contention
    rd_pat = p5a; lat_fix = 2;
    if_enable = 1'b1; if_addr = 64'h5010;
    dm_enable = 1'b1; dm_write = 1'b0; dm_addr = 64'h2040;
    e1 = -1; e2 = -1; cnt_if = 0; cnt_dm = 0; a1 = '0; a2 = '0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (mem_enable === 1'b1) begin
        if (e1 < 0) begin e1 = cyc; a1 = mem_addr; end
        else begin e2 = cyc; a2 = mem_addr; end
      end
      if (if_done === 1'b1) cnt_if++;
      if (dm_done === 1'b1) cnt_dm++;
    end
`ifdef ARB_RR_EN
    chk("contend_first", a1, 64'h5000);
    chk("contend_second", a2, 64'h2040);
`else
    chk("contend_first", a1, 64'h2040);
    chk("contend_second", a2, 64'h5000);
`endif
    chk("contend_if_cnt", cnt_if, 1);
    chk("contend_dm_cnt", cnt_dm, 1);
    chk("contend_gap", (e1 >= 0 && e2 - e1 >= 3), 1);
    chk("contend_dm_data", dm_rdata, p5a);

    // Data write
    lat_fix = 3;
    dm_enable = 1'b1; dm_write = 1'b1; dm_addr = 64'h3000; dm_wdata = pdead;
    cnt_dm = 0;
    for (int i = 0; i < 20 && cnt_dm == 0; i++) begin
      step();
      if (mem_enable === 1'b1 || mem_done === 1'b1) begin
        chk("wr_dir", mem_write, 1);
        chk("wr_wdata", mem_wdata, pdead);
        chk("wr_addr", mem_addr, 64'h3000);
      end
      if (dm_done === 1'b1) cnt_dm++;
    end
    chk("wr_done", cnt_dm, 1);
    chk("wr_rdata_kept", dm_rdata, p5a);
    dm_write = 1'b0;
    repeat (3) step();

    // Duplicate fetch pulses while in flight
    lat_fix = 4; cnt_en = 0; cnt_if = 0;
    if_enable = 1'b1; if_addr = 64'h7000;
    for (int i = 0; i < 25; i++) begin
      step();
      if (i == 1 || i == 4) begin if_enable = 1'b1; if_addr = 64'h8000; end
      if (mem_enable === 1'b1) cnt_en++;
      if (if_done === 1'b1) cnt_if++;
    end
    chk("dup_issue_cnt", cnt_en, 1);
    chk("dup_done_cnt", cnt_if, 1);
    chk("dup_addr", mem_addr, 64'h7000);

    // Reset while waiting on the port
    lat_fix = 6;
    if_enable = 1'b1; if_addr = 64'h9000;
    repeat (4) step();
    reset = 1'b1;
    step();
    cnt_if = 0; cnt_dm = 0; cnt_en = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (if_done === 1'b1) cnt_if++;
      if (dm_done === 1'b1) cnt_dm++;
      if (mem_enable === 1'b1) cnt_en++;
    end
    chk("rstw_if_done", cnt_if, 0);
    chk("rstw_dm_done", cnt_dm, 0);
    chk("rstw_issue", cnt_en, 0);
    chk("rstw_mem_addr", mem_addr, 0);
    chk("rstw_mem_write", mem_write, 0);
    chk("rstw_if_data", if_data, 0);

    // DM re-requests on every done while IF waits
    lat_fix = 3; ng = 0; n = 0; dmd = -1;
    ga[0] = '0; ga[1] = '0; ga[2] = '0;
    dm_enable = 1'b1; dm_addr = 64'hA000;
    step();
    if_enable = 1'b1; if_addr = 64'hB000;
    for (int i = 0; i < 40; i++) begin
      step();
      if (mem_enable === 1'b1) begin
        if (ng < 3) ga[ng] = mem_addr;
        if (ng == 1) chk("starve_if_timing", cyc - dmd, 1);
        ng++;
      end
      if (dm_done === 1'b1) begin
        if (dmd < 0) dmd = cyc;
        if (n < 2) begin
          dm_enable = 1'b1; dm_addr = 64'hA040 + 64'(n) * 64'h40; n++;
        end
      end
    end
    chk("starve_g0", ga[0], 64'hA000);
    chk("starve_g1", ga[1], 64'hB000);
    chk("starve_g2", ga[2], 64'hA040);

    // Random traffic with stray port completions and occasional resets
    lat_fix = 0; rd_fixed = 1'b0; stray_en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      step();
      if ($urandom_range(0, 399) == 0) reset = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        if_enable = 1'b1; if_addr = {$urandom, $urandom};
      end
      if ($urandom_range(0, 3) == 0) begin
        dm_enable = 1'b1; dm_write = 1'($urandom_range(0, 1));
        dm_addr = {$urandom, $urandom}; dm_wdata = rand512();
      end
    end
    stray_en = 1'b0;
    repeat (12) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
